ntt_butterfly: RTL and testbench
================================

// Module: ntt_butterfly
// PURPOSE
//  Pipelined Cooley-Tukey NTT butterfly, one butterfly per clock when not stalled.
//  Computes t = b*w mod q (Barrett), then x = (a+t) mod q and y = (a-t) mod q.
//  Sits between the coefficient/twiddle fetch logic and coefficient write-back.
//  Its final add/sub stage uses the same 2-cycle register-then-conditional-correct
//  scheme as the standalone modular adder.
// PARAMETERS
//  K    `K   coefficient/modulus width in bits; q < 2^K
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  mod        in   K      modulus q; odd, 2 < q < 2^K; static while any stage valid
//  mu         in   K+1    Barrett constant floor(2^(2K)/q); static with mod
//  in_valid   in   1      a/b/w valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  a          in   K      upper coefficient, a < q
//  b          in   K      lower coefficient, b < q
//  w          in   K      twiddle, w < q
//  out_valid  out  1      x/y valid
//  out_ready  in   1      consumer accepts x/y this cycle
//  x          out  K      (a + b*w) mod q
//  y          out  K      (a - b*w) mod q
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0, out_valid=0, x=y=0.
//    Reset mid-operation discards all in-flight butterflies.
//  - Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational).
//    Input is accepted when in_valid & in_ready.
//  - When adv=0, every stage register, including data and valid, holds.
//  - Bubbles propagate as valid=0. Data registers in invalid stages may update
//    freely but are not observable.
//  - Latency: exactly 7 advancing cycles from accept to out_valid. Throughput is 1/cycle.
//  - a is delayed alongside the multiply path and stays aligned with its t.
//  - S1: P = b*w (2K bits).
//  - S2: q2 = (P >> (K-1)) * mu.
//  - S3: r = P - ((q2 >> (K+1)) * q), kept in K+2 bits; 0 <= r < 3q.
//  - S4: if r >= q then r -= q.
//  - S5: if r >= q then r -= q, giving t < q.
//  - S6: s = a + t (K+1 bits); d = a - t (K+1 bits, two's complement).
//  - S7: x = (s - q) negative ? s : s - q.
//        y = d negative ? d + q : d.
//  - Widths: no truncation before the final K-bit result. All intermediates are
//    sized to hold their maximum value.
//  - Out-of-contract inputs (a, b or w >= q; wrong mu) give undefined x/y, but
//    handshake timing is unaffected.
//  - Simultaneous out_ready=1 and in_valid=1 while the pipe is full: one result
//    retires and one input enters in the same cycle.
// TESTING (K=14, q=12289, mu=21843)
//  1 a=5, b=3, w=7, out_ready=1
//    -> after 7 cycles out_valid=1 for 1 cycle, x=26, y=12273.
//  2 a=12288, b=12288, w=12288
//    -> x=0, y=12287 (t=1; sum wraps exactly to q).
//  3 a=0, b=0, w=5 -> x=0, y=0.
//    a=0, b=1, w=1 -> x=1, y=12288.
//  4 Stream 20 back-to-back random legal triples with out_ready=1
//    -> 20 consecutive valid outputs matching a golden model, in order, none
//       dropped or duplicated.
//  5 Stall: hold out_ready=0 for 5 cycles while out_valid=1
//    -> in_ready=0, and x/y/out_valid stable throughout.
//    Release -> stream resumes with no loss or duplication.
//  6 Assert rst_n=0 with 4 butterflies in flight
//    -> out_valid=0, x=y=0 immediately.
//    After release, no stale result ever appears.

Source files
------------

// File: rtl/ntt_butterfly.sv
// Pipelined Cooley-Tukey NTT butterfly: t = b*w mod q (Barrett), x = a+t mod q, y = a-t mod q.
// Seven register stages under one global advance; a result appears 7 advancing cycles after accept.
module ntt_butterfly #(
    parameter int K = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [K-1:0] mod,
    input  logic [K:0]   mu,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic [K-1:0] w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [K-1:0] x,
    output logic [K-1:0] y
);

    function automatic logic [K+1:0] cond_sub(input logic [K+1:0] r, input logic [K-1:0] q);
        return (r >= {2'b00, q}) ? r - {2'b00, q} : r;
    endfunction

    function automatic logic [K-1:0] fix_add(input logic [K:0] s, input logic [K-1:0] q);
        logic [K+1:0] sm;
        sm = {1'b0, s} - {2'b00, q};
        return sm[K+1] ? K'(s) : K'(sm);
    endfunction

    function automatic logic [K-1:0] fix_sub(input logic signed [K:0] d, input logic [K-1:0] q);
        logic [K:0] dq;
        dq = $unsigned(d) + {1'b0, q};
        return d[K] ? K'(dq) : K'(d);
    endfunction

    logic                  adv;
    logic                  vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6, vld_p7;
    logic [2*K-1:0]        p_p1, p_p2;
    logic [2*K+1:0]        q2_p2;
    logic [K+1:0]          r_p3, r_p4;
    logic [K-1:0]          t_p5;
    logic [K-1:0]          a_p1, a_p2, a_p3, a_p4, a_p5;
    logic [K:0]            s_p6;
    logic signed [K:0]     d_p6;
    logic [K-1:0]          x_p7, y_p7;

    logic [K:0]            p_hi;
    logic [K:0]            qhat;
    logic [2*K:0]          qm;
    logic [2*K:0]          diff;

    assign adv       = !vld_p7 || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_p7;
    assign x         = x_p7;
    assign y         = y_p7;

    // Barrett quotient estimate; the remainder fits in K+2 bits so the wider difference wraps harmlessly
    assign p_hi = (K+1)'(p_p1 >> (K-1));
    assign qhat = (K+1)'(q2_p2 >> (K+1));
    assign qm   = (2*K+1)'(qhat) * (2*K+1)'(mod);
    assign diff = (2*K+1)'(p_p2) - qm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
            vld_p4 <= 1'b0;
            vld_p5 <= 1'b0;
            vld_p6 <= 1'b0;
            vld_p7 <= 1'b0;
            x_p7   <= '0;
            y_p7   <= '0;
        end else if (adv) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
            vld_p4 <= vld_p3;
            vld_p5 <= vld_p4;
            vld_p6 <= vld_p5;
            vld_p7 <= vld_p6;
            // S7: final conditional correction into [0, q)
            x_p7   <= fix_add(s_p6, mod);
            y_p7   <= fix_sub(d_p6, mod);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            // S1: full product
            p_p1  <= (2*K)'(b) * (2*K)'(w);
            a_p1  <= a;
            // S2: quotient pre-multiply
            p_p2  <= p_p1;
            q2_p2 <= (2*K+2)'(p_hi) * (2*K+2)'(mu);
            a_p2  <= a_p1;
            // S3..S5: remainder and two corrections
            r_p3  <= (K+2)'(diff);
            a_p3  <= a_p2;
            r_p4  <= cond_sub(r_p3, mod);
            a_p4  <= a_p3;
            t_p5  <= K'(cond_sub(r_p4, mod));
            a_p5  <= a_p4;
            // S6: raw sum and signed difference
            s_p6  <= {1'b0, a_p5} + {1'b0, t_p5};
            d_p6  <= $signed({1'b0, a_p5}) - $signed({1'b0, t_p5});
        end
    end

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly at K=14, q=12289.
// Expected x/y are queued when an input is accepted and compared when a result retires.
module tb_ntt_butterfly;

    localparam int K  = 14;
    localparam int Q  = 12289;
    localparam int MU = 21843;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [K-1:0] mod = K'(Q);
    logic [K:0]   mu = (K+1)'(MU);
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [K-1:0] a = '0, b = '0, w = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [K-1:0] x, y;

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    int qx[$];
    int qy[$];

    ntt_butterfly #(.K(K)) dut (
        .clk(clk), .rst_n(rst_n), .mod(mod), .mu(mu),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .w(w),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_x(input int aa, input int bb, input int ww);
        longint t;
        t = (longint'(bb) * longint'(ww)) % Q;
        return int'((longint'(aa) + t) % Q);
    endfunction

    function automatic int model_y(input int aa, input int bb, input int ww);
        longint t;
        t = (longint'(bb) * longint'(ww)) % Q;
        return int'((longint'(aa) - t + Q) % Q);
    endfunction

    // Scoreboard: push on accept, pop on retire, both sampled at the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                qx.push_back(model_x(int'(a), int'(b), int'(w)));
                qy.push_back(model_y(int'(a), int'(b), int'(w)));
            end
            if (out_valid && out_ready) begin
                if (qx.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    chk("x", longint'(x), longint'(qx.pop_front()));
                    chk("y", longint'(y), longint'(qy.pop_front()));
                    n_out++;
                end
            end
        end
    end

    task automatic send(input int aa, input int bb, input int ww);
        int guard;
        guard = 0;
        a = K'(aa); b = K'(bb); w = K'(ww);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (out_valid) break;
            if (cycles > 200) begin
                chk("out_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic directed(input string tag, input int aa, input int bb, input int ww,
                            input int ex, input int ey);
        int cyc;
        send(aa, bb, ww);
        wait_out(cyc);
        chk({tag, "_lat"}, cyc, 7);
        chk({tag, "_x"}, longint'(x), ex);
        chk({tag, "_y"}, longint'(y), ey);
        @(negedge clk);
        chk({tag, "_pulse"}, longint'(out_valid), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        logic [K-1:0] hx, hy;

        #12;
        chk("rst_vld", longint'(out_valid), 0);
        chk("rst_x", longint'(x), 0);
        chk("rst_y", longint'(y), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("t1", 5, 3, 7, 26, 12273);
        directed("t2", 12288, 12288, 12288, 0, 12287);
        directed("t3a", 0, 0, 5, 0, 0);
        directed("t3b", 0, 1, 1, 1, 12288);

        // Back-to-back random stream
        n_out = 0;
        for (int i = 0; i < 20; i++)
            send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
        repeat (12) @(posedge clk);
        #1;
        chk("stream_count", n_out, 20);

        // Stall with a full output stage
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
        wait_out(cyc);
        hx = x; hy = y;
        a = K'(100); b = K'(200); w = K'(300);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_vld", longint'(out_valid), 1);
            chk("stall_x", longint'(x), longint'(hx));
            chk("stall_y", longint'(y), longint'(hy));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("stall_drain", qx.size(), 0);

        // Reset with four butterflies in flight
        for (int i = 0; i < 4; i++)
            send(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)));
        rst_n = 1'b0;
        #1;
        chk("mrst_vld", longint'(out_valid), 0);
        chk("mrst_x", longint'(x), 0);
        chk("mrst_y", longint'(y), 0);
        qx.delete();
        qy.delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_vld", longint'(out_valid), 0);
        end
        @(posedge clk); #1;
        directed("after_rst", 17, 12288, 2, 15, 19);

        chk("final_drain", qx.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
